// File: rtl/bist_pattern_gen_if.sv
// Pattern/compactor bus between the BIST generator and the AES datapath + MISR.
// The master drives patterns and compactor strobes; the slave returns ready and signature.
interface bist_pattern_gen_if #(
    parameter int WIDTH = 8
);
    logic             pat_valid;
    logic             pat_ready;
    logic [WIDTH-1:0] pat_data;
    logic             misr_rst;
    logic             misr_en;
    logic [WIDTH-1:0] signature_in;

    modport master (
        output pat_valid,
        output pat_data,
        output misr_rst,
        output misr_en,
        input  pat_ready,
        input  signature_in
    );

    modport slave (
        input  pat_valid,
        input  pat_data,
        input  misr_rst,
        input  misr_en,
        output pat_ready,
        output signature_in
    );
endinterface

// File: rtl/bist_pattern_gen.sv
// LFSR test-pattern generator and BIST sequencer: issues patterns, runs the
// compactor through its pipeline flush, then checks its signature against GOLDEN.
module bist_pattern_gen #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] TAPS         = 8'hB8,
    parameter logic [WIDTH-1:0] SEED         = 8'h01,
    parameter int               NUM_PATTERNS = 256,
    parameter int               FLUSH_CYCLES = 17,
    parameter logic [WIDTH-1:0] GOLDEN       = 8'h00
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    bist_pattern_gen_if.master   bus,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o
);

    localparam int PW = $clog2(NUM_PATTERNS + 1);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [PW-1:0] PAT_LAST   = PW'(NUM_PATTERNS - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

    // An all-zero seed locks the LFSR, and zero-length phases cannot be sequenced.
    if (SEED == '0) begin : g_bad_seed
        $error("bist_pattern_gen: SEED must be nonzero");
    end
    if (NUM_PATTERNS < 1) begin : g_bad_patterns
        $error("bist_pattern_gen: NUM_PATTERNS must be >= 1");
    end
    if (FLUSH_CYCLES < 1) begin : g_bad_flush
        $error("bist_pattern_gen: FLUSH_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        COMPARE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [PW-1:0]    patCnt_q, patCnt_d;
    logic [FW-1:0]    flushCnt_q, flushCnt_d;
    logic             pass_q, pass_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED;
            patCnt_q   <= '0;
            flushCnt_q <= '0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            patCnt_q   <= patCnt_d;
            flushCnt_q <= flushCnt_d;
            pass_q     <= pass_d;
        end
    end

    // Strobes decode from state; only misr_en in RUN follows pat_ready so the
    // compactor sees exactly the accepted patterns.
    always_comb begin
        state_d       = state_q;
        lfsr_d        = lfsr_q;
        patCnt_d      = patCnt_q;
        flushCnt_d    = flushCnt_q;
        pass_d        = pass_q;
        bus.pat_valid = 1'b0;
        bus.misr_rst  = 1'b0;
        bus.misr_en   = 1'b0;
        busy_o        = 1'b0;
        done_o        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) state_d = CLEAR;
            end
            CLEAR: begin
                bus.misr_rst = 1'b1;
                busy_o       = 1'b1;
                lfsr_d       = SEED;
                patCnt_d     = '0;
                flushCnt_d   = '0;
                pass_d       = 1'b0;
                state_d      = RUN;
            end
            RUN: begin
                bus.pat_valid = 1'b1;
                bus.misr_en   = bus.pat_ready;
                busy_o        = 1'b1;
                if (bus.pat_ready) begin
                    lfsr_d   = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
                    patCnt_d = patCnt_q + 1'b1;
                    if (patCnt_q == PAT_LAST) state_d = DRAIN;
                end
            end
            DRAIN: begin
                bus.misr_en = 1'b1;
                busy_o      = 1'b1;
                flushCnt_d  = flushCnt_q + 1'b1;
                if (flushCnt_q == FLUSH_LAST) state_d = COMPARE;
            end
            COMPARE: begin
                busy_o  = 1'b1;
                pass_d  = (bus.signature_in == GOLDEN);
                state_d = DONE;
            end
            DONE: begin
                done_o = 1'b1;
                if (start_i) state_d = CLEAR;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.pat_data = lfsr_q;
    assign pass_o       = pass_q;

endmodule

// File: tb/tb_bist_pattern_gen.sv
// Randomized self-checking bench for bist_pattern_gen: a short-run instance for
// handshake/sequencing behaviour and a 256-pattern instance for LFSR wrap.
module tb_bist_pattern_gen;

    localparam int         WIDTH  = 8;
    localparam logic [7:0] TAPS   = 8'hB8;
    localparam logic [7:0] SEED   = 8'h01;
    localparam logic [7:0] GOLDEN = 8'h00;
    localparam int         NPAT   = 4;
    localparam int         NFLUSH = 17;
    localparam int         NWRAP  = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, startA, startB;
    logic busyA, doneA, passA, busyB, doneB, passB;

    int errorCount = 0;
    int checkCount = 0;
    logic [7:0] expSeq [0:511];

    bist_pattern_gen_if #(.WIDTH(WIDTH)) busA ();
    bist_pattern_gen_if #(.WIDTH(WIDTH)) busB ();

    bist_pattern_gen #(
        .WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED),
        .NUM_PATTERNS(NPAT), .FLUSH_CYCLES(NFLUSH), .GOLDEN(GOLDEN)
    ) dutA (
        .clk_i(clk), .rst_i(rst), .start_i(startA), .bus(busA.master),
        .busy_o(busyA), .done_o(doneA), .pass_o(passA)
    );

    bist_pattern_gen #(
        .WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED),
        .NUM_PATTERNS(NWRAP), .FLUSH_CYCLES(NFLUSH), .GOLDEN(GOLDEN)
    ) dutB (
        .clk_i(clk), .rst_i(rst), .start_i(startB), .bus(busB.master),
        .busy_o(busyB), .done_o(doneB), .pass_o(passB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One complete run on dutA: optional random stalls, optional ignored start
    // pokes while busy, and the signature presented during the compare cycle.
    task automatic applyStimulus(input bit randomReady, input bit pokeStart, input logic [7:0] sigValue);
        int   h       = 0;
        int   budget  = 0;
        int   enCount = 0;
        logic rdy;
        @(negedge clk);
        startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        checkOutput("clear_misr_rst", 32'(busA.misr_rst), 1);
        checkOutput("clear_busy", 32'(busyA), 1);
        checkOutput("clear_done", 32'(doneA), 0);
        checkOutput("clear_valid", 32'(busA.pat_valid), 0);
        checkOutput("clear_misr_en", 32'(busA.misr_en), 0);
        while (h < NPAT && budget < 200) begin
            @(negedge clk);
            budget++;
            checkOutput("run_valid", 32'(busA.pat_valid), 1);
            checkOutput("run_data", 32'(busA.pat_data), 32'(expSeq[h]));
            checkOutput("run_misr_rst", 32'(busA.misr_rst), 0);
            rdy = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            busA.pat_ready    = rdy;
            busA.signature_in = 8'($urandom);
            startA = pokeStart ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            checkOutput("run_misr_en", 32'(busA.misr_en), 32'(rdy));
            if (busA.misr_en) enCount++;
            if (rdy) h++;
        end
        checkOutput("run_handshakes", 32'(h), NPAT);
        for (int i = 0; i < NFLUSH; i++) begin
            @(negedge clk);
            checkOutput("drain_valid", 32'(busA.pat_valid), 0);
            checkOutput("drain_misr_en", 32'(busA.misr_en), 1);
            checkOutput("drain_busy", 32'(busyA), 1);
            checkOutput("drain_done", 32'(doneA), 0);
            if (busA.misr_en) enCount++;
            busA.pat_ready    = 1'($urandom_range(0, 1));
            busA.signature_in = 8'($urandom);
            startA = pokeStart ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        @(negedge clk);
        checkOutput("cmp_misr_en", 32'(busA.misr_en), 0);
        checkOutput("cmp_busy", 32'(busyA), 1);
        checkOutput("cmp_done", 32'(doneA), 0);
        startA            = 1'b0;
        busA.signature_in = sigValue;
        @(negedge clk);
        busA.signature_in = 8'($urandom);
        checkOutput("done_done", 32'(doneA), 1);
        checkOutput("done_busy", 32'(busyA), 0);
        checkOutput("done_pass", 32'(passA), 32'(sigValue == GOLDEN));
        checkOutput("done_valid", 32'(busA.pat_valid), 0);
        checkOutput("misr_en_total", 32'(enCount), NPAT + NFLUSH);
        @(negedge clk);
        checkOutput("done_hold", 32'(doneA), 1);
        checkOutput("pass_hold", 32'(passA), 32'(sigValue == GOLDEN));
    endtask

    task automatic applyResetInDrain();
        @(negedge clk);
        startA = 1'b1;
        @(negedge clk);
        startA         = 1'b0;
        busA.pat_ready = 1'b1;
        repeat (NPAT + 3) @(negedge clk);
        checkOutput("pre_rst_in_drain", 32'({busA.pat_valid, busA.misr_en, busyA}), 32'(3'b011));
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_outputs",
                    32'({busA.pat_valid, busA.misr_rst, busA.misr_en, busyA, doneA, passA}), 0);
        checkOutput("rst_data", 32'(busA.pat_data), 32'(SEED));
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_stays_idle", 32'({busyA, doneA}), 0);
    endtask

    task automatic applyStartWithReset();
        @(negedge clk);
        rst    = 1'b1;
        startA = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        startA = 1'b0;
        checkOutput("rst_wins_misr_rst", 32'(busA.misr_rst), 0);
        checkOutput("rst_wins_busy", 32'(busyA), 0);
        @(negedge clk);
        checkOutput("rst_wins_idle", 32'({busyA, busA.misr_rst, doneA}), 0);
    endtask

    task automatic applyWrapRun();
        logic [7:0] got [0:NWRAP-1];
        bit         seen [0:255];
        int k = 0, dup = 0, zero = 0, seqErr = 0, budget = 0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        @(negedge clk);
        startB = 1'b1;
        @(negedge clk);
        startB = 1'b0;
        while (!doneB && budget < 600) begin
            @(negedge clk);
            budget++;
            if (busB.pat_valid && k < NWRAP) begin
                got[k] = busB.pat_data;
                k++;
            end
        end
        checkOutput("wrap_count", 32'(k), NWRAP);
        checkOutput("wrap_done", 32'(doneB), 1);
        for (int i = 0; i < k; i++) begin
            if (got[i] !== expSeq[i]) seqErr++;
            if (i < 255) begin
                if (got[i] == 8'h00) zero++;
                if (seen[got[i]]) dup++;
                seen[got[i]] = 1'b1;
            end
        end
        checkOutput("wrap_seq", 32'(seqErr), 0);
        checkOutput("wrap_distinct", 32'(dup), 0);
        checkOutput("wrap_nonzero", 32'(zero), 0);
        if (k == NWRAP) begin
            checkOutput("wrap_pat4", 32'(got[4]), 32'h11);
            checkOutput("wrap_pat5", 32'(got[5]), 32'h23);
            checkOutput("wrap_pat6", 32'(got[6]), 32'h47);
            checkOutput("wrap_last", 32'(got[NWRAP-1]), 32'h01);
        end
        checkOutput("wrap_pass", 32'(passB), 1);
    endtask

    initial begin
        logic [7:0] x;
        logic       sigR;
        expSeq[0] = SEED;
        for (int i = 1; i < 512; i++) begin
            x         = expSeq[i-1];
            expSeq[i] = {x[6:0], 1'($countones(x & TAPS) % 2)};
        end

        rst               = 1'b1;
        startA            = 1'b0;
        startB            = 1'b0;
        busA.pat_ready    = 1'b0;
        busA.signature_in = 8'h00;
        busB.pat_ready    = 1'b1;
        busB.signature_in = GOLDEN;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs",
                    32'({busA.pat_valid, busA.misr_rst, busA.misr_en, busyA, doneA, passA}), 0);
        checkOutput("reset_data", 32'(busA.pat_data), 32'(SEED));
        checkOutput("reset_b_busy", 32'(busyB), 0);
        rst = 1'b0;

        applyStimulus(1'b0, 1'b0, GOLDEN);
        applyStimulus(1'b1, 1'b0, 8'h5A);
        applyStimulus(1'b1, 1'b1, GOLDEN);
        applyResetInDrain();
        applyStimulus(1'b0, 1'b0, GOLDEN);
        applyStartWithReset();
        for (int r = 0; r < 3; r++) begin
            sigR = 1'($urandom_range(0, 1));
            applyStimulus(1'b1, 1'b1, sigR ? GOLDEN : 8'($urandom_range(1, 255)));
        end
        applyWrapRun();

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
